// File: rtl/int_stack_sequencer_if.sv
// Signal bundle between the interrupt stack sequencer and the surrounding pipeline.
// The master modport is the sequencer itself; slave is the pipeline/memory side.
interface int_stack_sequencer_if;
  logic        int_req;
  logic        rti_req;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        push;
  logic        pop;
  logic        int_active;
  logic [1:0]  int_count;
  logic [31:0] save_pc;
  logic [2:0]  save_flags;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        flags_restore;
  logic [2:0]  flags_out;
  logic        int_ack;

  modport master (
    input  int_req, rti_req, pc_in, flags_in, mem_rdata,
    output push, pop, int_active, int_count, save_pc, save_flags, stall,
           pc_load, pc_out, flags_restore, flags_out, int_ack
  );

  modport slave (
    output int_req, rti_req, pc_in, flags_in, mem_rdata,
    input  push, pop, int_active, int_count, save_pc, save_flags, stall,
           pc_load, pc_out, flags_restore, flags_out, int_ack
  );
endinterface

// File: rtl/int_stack_sequencer.sv
// Interrupt entry / return sequencer: pushes PC and flags as three 16-bit stack words,
// vectors the PC, and on return pops them back and restores PC and flags.
module int_stack_sequencer #(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0002
) (
  input logic                    clk,
  input logic                    rst,
  int_stack_sequencer_if.master  bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PUSH_PCH = 4'd1;
  localparam logic [3:0] PUSH_PCL = 4'd2;
  localparam logic [3:0] PUSH_FLG = 4'd3;
  localparam logic [3:0] VECTOR   = 4'd4;
  localparam logic [3:0] POP_FLG  = 4'd5;
  localparam logic [3:0] POP_PCL  = 4'd6;
  localparam logic [3:0] POP_PCH  = 4'd7;
  localparam logic [3:0] RESTORE  = 4'd8;

  logic [3:0]  stateQ, stateD;
  logic [31:0] savePcQ;
  logic [2:0]  saveFlagsQ;
  logic [31:0] pcQ;
  logic [2:0]  flagsQ;
  logic        intAccept;

  // rti_req wins a tie; the level int_req is still there next IDLE cycle.
  assign intAccept = (stateQ == IDLE) && !bus.rti_req && bus.int_req;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (bus.rti_req)      stateD = POP_FLG;
        else if (bus.int_req) stateD = PUSH_PCH;
      end
      PUSH_PCH: stateD = PUSH_PCL;
      PUSH_PCL: stateD = PUSH_FLG;
      PUSH_FLG: stateD = VECTOR;
      VECTOR:   stateD = IDLE;
      POP_FLG:  stateD = POP_PCL;
      POP_PCL:  stateD = POP_PCH;
      POP_PCH:  stateD = RESTORE;
      RESTORE:  stateD = IDLE;
      default:  stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      savePcQ    <= '0;
      saveFlagsQ <= '0;
      pcQ        <= '0;
      flagsQ     <= '0;
    end else begin
      stateQ <= stateD;
      if (intAccept) begin
        savePcQ    <= bus.pc_in;
        saveFlagsQ <= bus.flags_in;
      end
      case (stateQ)
        POP_FLG: flagsQ       <= bus.mem_rdata[2:0];
        POP_PCL: pcQ[15:0]    <= bus.mem_rdata;
        POP_PCH: pcQ[31:16]   <= bus.mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.push          = 1'b0;
    bus.pop           = 1'b0;
    bus.int_active    = 1'b0;
    bus.int_count     = 2'b00;
    bus.pc_load       = 1'b0;
    bus.flags_restore = 1'b0;
    bus.int_ack       = 1'b0;
    bus.pc_out        = pcQ;
    case (stateQ)
      PUSH_PCH: begin bus.push = 1'b1; bus.int_active = 1'b1; bus.int_count = 2'b01; end
      PUSH_PCL: begin bus.push = 1'b1; bus.int_active = 1'b1; bus.int_count = 2'b10; end
      PUSH_FLG: begin bus.push = 1'b1; bus.int_active = 1'b1; bus.int_count = 2'b11; end
      VECTOR: begin
        bus.pc_load = 1'b1;
        bus.pc_out  = VECTOR_ADDR;
        bus.int_ack = 1'b1;
      end
      POP_FLG: begin bus.pop = 1'b1; bus.int_count = 2'b11; end
      POP_PCL: begin bus.pop = 1'b1; bus.int_count = 2'b10; end
      POP_PCH: begin bus.pop = 1'b1; bus.int_count = 2'b01; end
      RESTORE: begin
        bus.pc_load       = 1'b1;
        bus.flags_restore = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.stall      = (stateQ != IDLE);
  assign bus.save_pc    = savePcQ;
  assign bus.save_flags = saveFlagsQ;
  assign bus.flags_out  = flagsQ;

endmodule

// File: tb/tb_int_stack_sequencer.sv
// Directed bench for int_stack_sequencer: entry, return, tie priority, busy requests,
// and reset in the middle of a return sequence.
module tb_int_stack_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  int_stack_sequencer_if bus ();

  int_stack_sequencer #(
    .VECTOR_ADDR(32'h0000_0002)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {push, pop, int_active, int_count[1:0], stall, pc_load, flags_restore, int_ack}
  logic [8:0] ctl;
  assign ctl = {bus.push, bus.pop, bus.int_active, bus.int_count, bus.stall,
                bus.pc_load, bus.flags_restore, bus.int_ack};

  localparam logic [8:0] C_IDLE = 9'b0_0_0_00_0_0_0_0;
  localparam logic [8:0] C_PCH  = 9'b1_0_1_01_1_0_0_0;
  localparam logic [8:0] C_PCL  = 9'b1_0_1_10_1_0_0_0;
  localparam logic [8:0] C_PFL  = 9'b1_0_1_11_1_0_0_0;
  localparam logic [8:0] C_VEC  = 9'b0_0_0_00_1_1_0_1;
  localparam logic [8:0] C_OFL  = 9'b0_1_0_11_1_0_0_0;
  localparam logic [8:0] C_OPL  = 9'b0_1_0_10_1_0_0_0;
  localparam logic [8:0] C_OPH  = 9'b0_1_0_01_1_0_0_0;
  localparam logic [8:0] C_RST  = 9'b0_0_0_00_1_1_1_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (ctl !== C_IDLE) begin
      bad++; $display("FAIL reset ctl: got %b want %b", ctl, C_IDLE);
    end
    total++;
    if ({bus.save_pc, bus.save_flags, bus.pc_out, bus.flags_out} !== 70'd0) begin
      bad++;
      $display("FAIL reset regs: got save_pc=%h save_flags=%b pc_out=%h flags_out=%b want 0",
               bus.save_pc, bus.save_flags, bus.pc_out, bus.flags_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_int_entry();
    logic [8:0] exp [5] = '{C_PCH, C_PCL, C_PFL, C_VEC, C_IDLE};
    int stalls = 0;
    bus.pc_in    = 32'h0001_0040;
    bus.flags_in = 3'b101;
    bus.int_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      // Changing pc_in after acceptance must not disturb the latched copy.
      bus.pc_in    = 32'hDEAD_BEEF;
      bus.flags_in = 3'b010;
      if (bus.stall) stalls++;
      total++;
      if (ctl !== exp[i]) begin
        bad++; $display("FAIL entry ctl cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      if (i == 3) begin
        total++;
        if (bus.pc_out !== 32'h0000_0002) begin
          bad++; $display("FAIL entry vector pc_out: got %h want 00000002", bus.pc_out);
        end
        bus.int_req = 1'b0;
      end
    end
    total++;
    if (bus.save_pc !== 32'h0001_0040 || bus.save_flags !== 3'b101) begin
      bad++;
      $display("FAIL entry latch: got save_pc=%h save_flags=%b want 00010040 101",
               bus.save_pc, bus.save_flags);
    end
    total++;
    if (stalls !== 4) begin
      bad++; $display("FAIL entry stall cycles: got %0d want 4", stalls);
    end
  endtask

  task automatic test_rti();
    logic [8:0]  exp [5] = '{C_OFL, C_OPL, C_OPH, C_RST, C_IDLE};
    logic [15:0] dat [3] = '{16'h0005, 16'h0040, 16'h0001};
    bus.rti_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.rti_req   = 1'b0;
      bus.mem_rdata = (i < 3) ? dat[i] : 16'hFFFF;
      total++;
      if (ctl !== exp[i]) begin
        bad++; $display("FAIL rti ctl cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      if (i == 3) begin
        total++;
        if (bus.pc_out !== 32'h0001_0040 || bus.flags_out !== 3'b101) begin
          bad++;
          $display("FAIL rti restore: got pc_out=%h flags_out=%b want 00010040 101",
                   bus.pc_out, bus.flags_out);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0]  exp [10] = '{C_OFL, C_OPL, C_OPH, C_RST, C_IDLE,
                              C_PCH, C_PCL, C_PFL, C_VEC, C_IDLE};
    logic [15:0] dat [3] = '{16'h0003, 16'h0ABC, 16'h0007};
    bus.pc_in    = 32'h1234_5678;
    bus.flags_in = 3'b010;
    bus.int_req  = 1'b1;
    bus.rti_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.rti_req   = 1'b0;
      bus.mem_rdata = (i < 3) ? dat[i] : 16'h0000;
      total++;
      if (ctl !== exp[i]) begin
        bad++; $display("FAIL simul ctl cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      if (i == 3) begin
        total++;
        if (bus.pc_out !== 32'h0007_0ABC || bus.flags_out !== 3'b011) begin
          bad++;
          $display("FAIL simul restore: got pc_out=%h flags_out=%b want 00070abc 011",
                   bus.pc_out, bus.flags_out);
        end
      end
      if (i == 4) begin
        total++;
        if (bus.save_pc !== 32'h0001_0040) begin
          bad++; $display("FAIL simul early latch: got save_pc=%h want 00010040", bus.save_pc);
        end
      end
      if (i == 5) begin
        total++;
        if (bus.save_pc !== 32'h1234_5678 || bus.save_flags !== 3'b010) begin
          bad++;
          $display("FAIL simul latch: got save_pc=%h save_flags=%b want 12345678 010",
                   bus.save_pc, bus.save_flags);
        end
      end
      if (i == 8) bus.int_req = 1'b0;
    end
  endtask

  task automatic test_busy_requests();
    int pushes = 0;
    int pops   = 0;
    bus.pc_in   = 32'h0000_1111;
    bus.int_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.rti_req = (i == 1);
      if (bus.int_ack) bus.int_req = 1'b0;
      if (bus.push) pushes++;
      if (bus.pop) pops++;
      total++;
      if (bus.push && bus.pop) begin
        bad++; $display("FAIL busy push&pop cyc%0d: got both 1 want exclusive", i);
      end
    end
    total++;
    if (pushes !== 3 || pops !== 0) begin
      bad++; $display("FAIL busy counts: got push=%0d pop=%0d want 3 0", pushes, pops);
    end
    total++;
    if (ctl !== C_IDLE) begin
      bad++; $display("FAIL busy final ctl: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int restores = 0;
    bus.rti_req = 1'b1;
    tick();
    bus.rti_req   = 1'b0;
    bus.mem_rdata = 16'h0006;
    tick();
    total++;
    if (ctl !== C_OPL) begin
      bad++; $display("FAIL rstmid reach POP_PCL: got %b want %b", ctl, C_OPL);
    end
    bus.mem_rdata = 16'h0055;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (ctl !== C_IDLE) begin
      bad++; $display("FAIL rstmid ctl: got %b want %b", ctl, C_IDLE);
    end
    total++;
    if ({bus.save_pc, bus.save_flags, bus.pc_out, bus.flags_out} !== 70'd0) begin
      bad++;
      $display("FAIL rstmid regs: got save_pc=%h save_flags=%b pc_out=%h flags_out=%b want 0",
               bus.save_pc, bus.save_flags, bus.pc_out, bus.flags_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.flags_restore) restores++;
      total++;
      if (ctl !== C_IDLE) begin
        bad++; $display("FAIL rstmid resume cyc%0d: got %b want %b", i, ctl, C_IDLE);
      end
    end
    total++;
    if (restores !== 0) begin
      bad++; $display("FAIL rstmid flags_restore: got %0d want 0", restores);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.int_req   = 1'b0;
    bus.rti_req   = 1'b0;
    bus.pc_in     = '0;
    bus.flags_in  = '0;
    bus.mem_rdata = '0;
    test_reset();
    test_int_entry();
    test_rti();
    test_simultaneous();
    test_busy_requests();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
